// File: rtl/regfile_checker.sv
// Self-check engine: runs the core for a fixed number of cycles, then
// scans an expected-value table against the register file read port.
module regfile_checker #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int REG_ADDR_W  = 5,
   parameter  int NUM_CHECKS  = 9,
   parameter  int CYCLE_LIMIT = 12,
   localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int ERR_W = $clog2(NUM_CHECKS + 1),
   localparam int CNT_W = (CYCLE_LIMIT > 0) ? $clog2(CYCLE_LIMIT + 1) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  exp_we,
   input  logic [IDX_W-1:0]      exp_idx,
   input  logic                  exp_en,
   input  logic [REG_ADDR_W-1:0] exp_reg,
   input  logic [DATA_WIDTH-1:0] exp_value,
   output logic [REG_ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_WIDTH-1:0] rf_rd_data,
   output logic                  cpu_run,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      error_count,
   output logic [REG_ADDR_W-1:0] first_fail_reg,
   output logic [DATA_WIDTH-1:0] first_fail_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST =
      (CYCLE_LIMIT > 0) ? CNT_W'(CYCLE_LIMIT - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

   state_t r_state;
   state_t w_next;

   logic                  r_en  [NUM_CHECKS];
   logic [REG_ADDR_W-1:0] r_reg [NUM_CHECKS];
   logic [DATA_WIDTH-1:0] r_val [NUM_CHECKS];

   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_pend;
   logic [IDX_W-1:0]      r_pend_idx;
   logic [ERR_W-1:0]      r_err;
   logic                  r_pass;
   logic [REG_ADDR_W-1:0] r_ffr;
   logic [DATA_WIDTH-1:0] r_ffd;

   logic             w_open;
   logic             w_start_ok;
   logic             w_wr_ok;
   logic             w_miss;
   logic [ERR_W-1:0] w_err_nxt;

   assign w_open     = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_start_ok = start && w_open;
   assign w_wr_ok    = exp_we && w_open &&
                       ({1'b0, exp_idx} < (IDX_W + 1)'(NUM_CHECKS));
   assign w_miss     = r_pend && (rf_rd_data != r_val[r_pend_idx]);
   assign w_err_nxt  = r_err + ERR_W'(w_miss);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_next = (CYCLE_LIMIT == 0) ? S_SCAN : S_RUN;
         end
         S_RUN:   if (r_cnt == CNT_LAST) w_next = S_SCAN;
         S_SCAN:  if (r_idx == IDX_LAST) w_next = S_DRAIN;
         S_DRAIN: w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            r_en[i]  <= 1'b0;
            r_reg[i] <= '0;
            r_val[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_en[exp_idx]  <= exp_en;
         r_reg[exp_idx] <= exp_reg;
         r_val[exp_idx] <= exp_value;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_pend     <= 1'b0;
         r_pend_idx <= '0;
         r_err      <= '0;
         r_pass     <= 1'b0;
         r_ffr      <= '0;
         r_ffd      <= '0;
      end else if (w_start_ok) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_pend     <= 1'b0;
         r_pend_idx <= '0;
         r_err      <= '0;
         r_pass     <= 1'b0;
         r_ffr      <= '0;
         r_ffd      <= '0;
      end else begin
         if (r_state == S_RUN && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
         if (r_state == S_SCAN && r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
         // Issue stage: the slot's data returns next cycle for compare
         r_pend     <= (r_state == S_SCAN) && r_en[r_idx];
         r_pend_idx <= r_idx;
         if (w_miss) begin
            r_err <= w_err_nxt;
            if (r_err == '0) begin
               r_ffr <= r_reg[r_pend_idx];
               r_ffd <= rf_rd_data;
            end
         end
         if (r_state == S_DRAIN) r_pass <= (w_err_nxt == '0);
      end
   end

   assign rf_rd_addr      = (r_state == S_SCAN) ? r_reg[r_idx] : '0;
   assign cpu_run         = (r_state == S_RUN);
   assign busy            = (r_state == S_RUN) || (r_state == S_SCAN) ||
                            (r_state == S_DRAIN);
   assign done            = (r_state == S_DONE);
   assign pass            = r_pass;
   assign error_count     = r_err;
   assign first_fail_reg  = r_ffr;
   assign first_fail_data = r_ffd;

endmodule

// File: tb/tb_regfile_checker.sv
// Randomised bench for regfile_checker against a table-scan reference model.
module tb_regfile_checker;

   logic        clock = 1'b0;
   logic        reset;
   logic        start0, start1;
   logic        exp_we;
   logic [3:0]  exp_idx;
   logic        exp_en;
   logic [4:0]  exp_reg;
   logic [31:0] exp_value;

   logic [4:0]  addr0, addr1;
   logic [31:0] rd0, rd1;
   logic        run0_o, run1_o, busy0, busy1, done0, done1, pass0, pass1;
   logic [3:0]  err0, err1;
   logic [4:0]  ffr0, ffr1;
   logic [31:0] ffd0, ffd1;

   logic [31:0] mrf [32];
   logic        tb_en  [9];
   logic [4:0]  tb_reg [9];
   logic [31:0] tb_val [9];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      rd0 <= mrf[addr0];
      rd1 <= mrf[addr1];
   end

   regfile_checker u_dut0 (
      .clock(clock), .reset(reset), .start(start0),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_en(exp_en),
      .exp_reg(exp_reg), .exp_value(exp_value),
      .rf_rd_addr(addr0), .rf_rd_data(rd0),
      .cpu_run(run0_o), .busy(busy0), .done(done0), .pass(pass0),
      .error_count(err0), .first_fail_reg(ffr0), .first_fail_data(ffd0)
   );

   regfile_checker #(.CYCLE_LIMIT(0)) u_dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_en(exp_en),
      .exp_reg(exp_reg), .exp_value(exp_value),
      .rf_rd_addr(addr1), .rf_rd_data(rd1),
      .cpu_run(run1_o), .busy(busy1), .done(done1), .pass(pass1),
      .error_count(err1), .first_fail_reg(ffr1), .first_fail_data(ffd1)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(output int ec, output int fr,
                                 output logic [31:0] fd);
      ec = 0; fr = 0; fd = '0;
      for (int s = 0; s < 9; s++) begin
         if (tb_en[s] && mrf[tb_reg[s]] != tb_val[s]) begin
            if (ec == 0) begin
               fr = int'(tb_reg[s]);
               fd = mrf[tb_reg[s]];
            end
            ec++;
         end
      end
   endfunction

   task automatic wr(input int idx, input bit en, input int rg,
                     input logic [31:0] v);
      @(negedge clock);
      exp_we = 1'b1; exp_idx = 4'(idx); exp_en = en;
      exp_reg = 5'(rg); exp_value = v;
      tb_en[idx] = en; tb_reg[idx] = 5'(rg); tb_val[idx] = v;
      @(negedge clock);
      exp_we = 1'b0;
   endtask

   task automatic run0(input string tag, input bit disturb);
      int ec, fr, runs, lat;
      logic [31:0] fd;
      model(ec, fr, fd);
      @(negedge clock); start0 = 1'b1;
      @(posedge clock); #1; start0 = 1'b0;
      runs = 0; lat = -1;
      for (int k = 0; k < 100; k++) begin
         if (run0_o) runs++;
         if (done0) begin lat = k; break; end
         if (disturb && k == 15) begin
            start0 = 1'b1; exp_we = 1'b1; exp_idx = 4'd8; exp_en = 1'b1;
            exp_reg = 5'd0; exp_value = ~mrf[0];
         end else if (disturb && k == 16) begin
            start0 = 1'b0; exp_we = 1'b0;
         end
         @(posedge clock); #1;
      end
      chk({tag, "_lat"},  64'(lat), 64'd22);
      chk({tag, "_runs"}, 64'(runs), 64'd12);
      chk({tag, "_err"},  64'(err0), 64'(ec));
      chk({tag, "_pass"}, 64'(pass0), 64'(ec == 0));
      chk({tag, "_ffr"},  64'(ffr0), 64'(fr));
      chk({tag, "_ffd"},  64'(ffd0), 64'(fd));
      chk({tag, "_addr"}, 64'(addr0), 64'd0);
   endtask

   task automatic run1(input string tag);
      int ec, fr, runs, lat;
      logic [31:0] fd;
      model(ec, fr, fd);
      @(negedge clock); start1 = 1'b1;
      @(posedge clock); #1; start1 = 1'b0;
      chk({tag, "_addr0"}, 64'(addr1), 64'(tb_reg[0]));
      runs = 0; lat = -1;
      for (int k = 0; k < 100; k++) begin
         if (run1_o) runs++;
         if (done1) begin lat = k; break; end
         @(posedge clock); #1;
      end
      chk({tag, "_lat"},  64'(lat), 64'd10);
      chk({tag, "_runs"}, 64'(runs), 64'd0);
      chk({tag, "_err"},  64'(err1), 64'(ec));
      chk({tag, "_pass"}, 64'(pass1), 64'(ec == 0));
      chk({tag, "_ffr"},  64'(ffr1), 64'(fr));
      chk({tag, "_ffd"},  64'(ffd1), 64'(fd));
   endtask

   initial begin
      int dir_reg [9];
      int dir_val [9];
      dir_reg = '{2, 3, 4, 5, 6, 7, 8, 11, 1};
      dir_val = '{2, 5, 2, 2, 3, 12, 6, 12, 1};
      reset = 1'b0; start0 = 1'b0; start1 = 1'b0; exp_we = 1'b0;
      exp_idx = '0; exp_en = 1'b0; exp_reg = '0; exp_value = '0;
      for (int r = 0; r < 32; r++) mrf[r] = $urandom;
      for (int s = 0; s < 9; s++) begin
         tb_en[s] = 1'b0; tb_reg[s] = '0; tb_val[s] = '0;
      end
      repeat (3) @(posedge clock);
      #1;
      chk("rst_run",  64'(run0_o), 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_done", 64'(done0), 64'd0);
      chk("rst_pass", 64'(pass0), 64'd0);
      chk("rst_err",  64'(err0), 64'd0);
      chk("rst_addr", 64'(addr0), 64'd0);
      @(negedge clock); reset = 1'b1;

      for (int s = 0; s < 9; s++) begin
         mrf[dir_reg[s]] = 32'(dir_val[s]);
         wr(s, 1'b1, dir_reg[s], 32'(dir_val[s]));
      end
      run0("match", 1'b0);

      mrf[7] = 32'd13; mrf[1] = 32'd0;
      run0("twofail", 1'b0);
      chk("twofail_cnt", 64'(err0), 64'd2);
      chk("twofail_reg", 64'(ffr0), 64'd7);
      chk("twofail_dat", 64'(ffd0), 64'd13);

      mrf[7] = 32'd12; mrf[1] = 32'd1; mrf[4] = 32'd99;
      wr(2, 1'b0, 4, 32'd2);
      run0("skip", 1'b0);
      chk("skip_pass", 64'(pass0), 64'd1);

      run1("cl0");

      mrf[0] = 32'h1234_5678;
      wr(8, 1'b1, 0, 32'h1234_5678);
      run0("disturb", 1'b1);
      wr(8, tb_en[8], int'(tb_reg[8]), tb_val[8]);

      for (int it = 0; it < 6; it++) begin
         for (int r = 0; r < 32; r++) mrf[r] = $urandom;
         for (int s = 0; s < 9; s++) begin
            int rg;
            logic [31:0] v;
            rg = int'($urandom % 32);
            v = mrf[rg];
            if ($urandom % 3 == 0) v = v ^ (32'd1 << ($urandom % 32));
            wr(s, ($urandom % 4) != 0, rg, v);
         end
         run0($sformatf("rnd%0d", it), 1'b0);
         if (it % 2 == 0) run1($sformatf("rnd1_%0d", it));
      end

      @(negedge clock); start0 = 1'b1;
      @(posedge clock); #1; start0 = 1'b0;
      repeat (4) @(posedge clock);
      #1; reset = 1'b0;
      #1;
      chk("mid_run",  64'(run0_o), 64'd0);
      chk("mid_busy", 64'(busy0), 64'd0);
      chk("mid_done", 64'(done0), 64'd0);
      chk("mid_err",  64'(err0), 64'd0);
      chk("mid_ffr",  64'(ffr0), 64'd0);
      chk("mid_ffd",  64'(ffd0), 64'd0);
      @(negedge clock); reset = 1'b1;
      for (int s = 0; s < 9; s++) begin
         tb_en[s] = 1'b0; tb_reg[s] = '0; tb_val[s] = '0;
      end
      run0("empty", 1'b0);
      chk("empty_pass", 64'(pass0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
